// File: rtl/execute_stage.sv
// execute_stage -- EX stage of the 5-stage RV32IM pipeline.
//
// Computes RV32I ALU results in a single cycle. Computes M-extension results
// with an iterative 32-step shift-add / restoring-divide engine. Registers the
// EX/MEM packet consumed by the memory stage.
//
// Ports:
//   clk, reset           clock (rising edge); asynchronous active-low reset
//   valid_in             ID/EX holds a real instruction
//   alu_op, alu_src      ALU operation; operand B select (1 = imm, 0 = rs2_data)
//   is_muldiv, md_op     M-extension instruction and its funct3
//   rs1_data, rs2_data   register operands (rs2_data is also the store data)
//   imm, rd              sign-extended immediate; destination register
//   RegWrite, MemToReg,  control bits passed through to EX/MEM
//   MemWrite
//   flush                kill the instruction in EX and abort any mul/div
//   stall                hold PC, IF/ID and ID/EX while mul/div is running
//   ex_mem               registered EX/MEM packet

package execute_pkg;
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        MemToReg;
    logic        MemWrite;
  } ex_mem_t;
endpackage

module execute_stage #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [3:0]           alu_op,
  input  logic                 alu_src,
  input  logic                 is_muldiv,
  input  logic [2:0]           md_op,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [XLEN-1:0]      imm,
  input  logic [4:0]           rd,
  input  logic                 RegWrite,
  input  logic                 MemToReg,
  input  logic                 MemWrite,
  input  logic                 flush,
  output logic                 stall,
  output execute_pkg::ex_mem_t ex_mem
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  localparam logic [4:0] LastIter = 5'(MD_CYCLES - 1);

  state_e               state_q, state_d;
  logic [63:0]          acc_q, acc_d;
  logic [31:0]          opB_q, opB_d;
  logic [4:0]           iter_q, iter_d;
  logic [2:0]           mdOp_q, mdOp_d;
  logic                 negRes_q, negRes_d;
  logic                 special_q, special_d;
  logic [31:0]          specialVal_q, specialVal_d;
  execute_pkg::ex_mem_t exMem_q, exMem_d;
  logic                 stallRaw;

  logic [31:0] aluB, aluResult;
  logic        signA, signB;
  logic [31:0] magA, magB;
  logic [32:0] mulSum, divTmp, divSub;
  logic        divGe;
  logic [63:0] mulNext, divNext, product;
  logic [31:0] divSel, mulRes, divRes, mdResult;

  // Single-cycle RV32I ALU; shift amounts come from B[4:0].
  always_comb begin
    aluB      = alu_src ? imm : rs2_data;
    aluResult = '0;
    case (alu_op)
      4'd0:    aluResult = rs1_data + aluB;
      4'd1:    aluResult = rs1_data - aluB;
      4'd2:    aluResult = rs1_data & aluB;
      4'd3:    aluResult = rs1_data | aluB;
      4'd4:    aluResult = rs1_data ^ aluB;
      4'd5:    aluResult = rs1_data << aluB[4:0];
      4'd6:    aluResult = rs1_data >> aluB[4:0];
      4'd7:    aluResult = $signed(rs1_data) >>> aluB[4:0];
      4'd8:    aluResult = {31'b0, $signed(rs1_data) < $signed(aluB)};
      4'd9:    aluResult = {31'b0, rs1_data < aluB};
      4'd10:   aluResult = aluB;
      default: aluResult = '0;
    endcase
  end

  // Operand preparation at latch time. The engine works on magnitudes only;
  // the sign of the final result is remembered in negRes.
  always_comb begin
    signA = rs1_data[31] & (md_op inside {3'd1, 3'd2, 3'd4, 3'd6});
    signB = rs2_data[31] & (md_op inside {3'd1, 3'd4, 3'd6});
    magA  = signA ? (32'd0 - rs1_data) : rs1_data;
    magB  = signB ? (32'd0 - rs2_data) : rs2_data;
  end

  // One engine step. Multiply: add the multiplicand into the high half when
  // the current multiplier bit is set, then shift right. Divide: shift the
  // remainder/quotient pair left and subtract the divisor when it fits.
  always_comb begin
    mulSum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opB_q} : 33'd0);
    mulNext = {mulSum, acc_q[31:1]};
    divTmp  = {acc_q[63:32], acc_q[31]};
    divGe   = divTmp >= {1'b0, opB_q};
    divSub  = divTmp - {1'b0, opB_q};
    divNext = {divGe ? divSub[31:0] : divTmp[31:0], acc_q[30:0], divGe};
  end

  // Final sign fix-up; divide-by-zero and signed overflow override the engine.
  always_comb begin
    product  = negRes_q ? (64'd0 - acc_q) : acc_q;
    mulRes   = (mdOp_q[1:0] == 2'd0) ? product[31:0] : product[63:32];
    divSel   = mdOp_q[1] ? acc_q[63:32] : acc_q[31:0];
    divRes   = negRes_q ? (32'd0 - divSel) : divSel;
    mdResult = special_q ? specialVal_q : (mdOp_q[2] ? divRes : mulRes);
  end

  // FSM next state, engine datapath and EX/MEM packet.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    opB_d        = opB_q;
    iter_d       = iter_q;
    mdOp_d       = mdOp_q;
    negRes_d     = negRes_q;
    special_d    = special_q;
    specialVal_d = specialVal_q;
    exMem_d      = '0;
    stallRaw     = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in && is_muldiv) begin
            state_d      = BUSY;
            stallRaw     = 1'b1;
            acc_d        = {32'd0, magA};
            opB_d        = magB;
            iter_d       = '0;
            mdOp_d       = md_op;
            negRes_d     = (md_op[2] && md_op[1]) ? signA : (signA ^ signB);
            special_d    = 1'b0;
            specialVal_d = '0;
            if (md_op[2] && rs2_data == 32'd0) begin
              special_d    = 1'b1;
              specialVal_d = md_op[1] ? rs1_data : 32'hFFFF_FFFF;
            end else if (!md_op[0] && md_op[2] && rs1_data == 32'h8000_0000 &&
                         rs2_data == 32'hFFFF_FFFF) begin
              special_d    = 1'b1;
              specialVal_d = md_op[1] ? 32'd0 : 32'h8000_0000;
            end
          end else if (valid_in) begin
            exMem_d.alu_result = aluResult;
            exMem_d.rs2_data   = rs2_data;
            exMem_d.rd         = rd;
            exMem_d.RegWrite   = RegWrite;
            exMem_d.MemToReg   = MemToReg;
            exMem_d.MemWrite   = MemWrite;
          end
        end
        BUSY: begin
          stallRaw = 1'b1;
          acc_d    = mdOp_q[2] ? divNext : mulNext;
          iter_d   = iter_q + 5'd1;
          if (iter_q == LastIter) state_d = DONE;
        end
        DONE: begin
          // ID/EX still holds the mul/div instruction thanks to the stall.
          exMem_d.alu_result = mdResult;
          exMem_d.rs2_data   = rs2_data;
          exMem_d.rd         = rd;
          exMem_d.RegWrite   = RegWrite;
          exMem_d.MemToReg   = MemToReg;
          exMem_d.MemWrite   = MemWrite;
          state_d            = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stall drops as soon as reset is asserted, independent of the clock.
  assign stall  = stallRaw & reset;
  assign ex_mem = exMem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      opB_q        <= '0;
      iter_q       <= '0;
      mdOp_q       <= '0;
      negRes_q     <= 1'b0;
      special_q    <= 1'b0;
      specialVal_q <= '0;
      exMem_q      <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      opB_q        <= opB_d;
      iter_q       <= iter_d;
      mdOp_q       <= mdOp_d;
      negRes_q     <= negRes_d;
      special_q    <= special_d;
      specialVal_q <= specialVal_d;
      exMem_q      <= exMem_d;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage -- self-checking bench for execute_stage.
// Expected EX/MEM packets are pushed to a scoreboard queue when stimulus is
// driven and popped when the DUT produces them.

module tb_execute_stage;
  import execute_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic        is_muldiv;
  logic [2:0]  md_op;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  rd;
  logic        RegWrite, MemToReg, MemWrite;
  logic        flush;
  logic        stall;
  ex_mem_t     ex_mem;

  ex_mem_t exp_q[$];
  ex_mem_t exp_pkt;
  int      checks   = 0;
  int      failures = 0;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [4:0]  d;
    logic        rw;
    logic        m2r;
    logic        mw;
  } alu_vec_t;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op),
    .alu_src(alu_src), .is_muldiv(is_muldiv), .md_op(md_op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .MemWrite(MemWrite),
    .flush(flush), .stall(stall), .ex_mem(ex_mem)
  );

  // Reference ALU
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return 32'($signed(a) >>> b[4:0]);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  // Reference M-extension using native 64-bit arithmetic
  function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin r = sa * sb; return r[31:0]; end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * ub; return r[63:32]; end
      3'd3: begin r = ua * ub; return r[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; r = sa / sb; return r[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; r = sa % sb; return r[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  task automatic applyStimulus(input logic v, input logic [3:0] aop, input logic asrc,
                               input logic md, input logic [2:0] mop, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] im,
                               input logic [4:0] d, input logic rw, input logic m2r,
                               input logic mw);
    valid_in = v;   alu_op = aop;   alu_src = asrc; is_muldiv = md; md_op = mop;
    rs1_data = a;   rs2_data = b;   imm = im;       rd = d;
    RegWrite = rw;  MemToReg = m2r; MemWrite = mw;  flush = 1'b0;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d);
    ex_mem_t p;
    p.alu_result = alu_model(op, a, b);
    p.rs2_data = b; p.rd = d; p.RegWrite = 1'b1; p.MemToReg = 1'b0; p.MemWrite = 1'b0;
    exp_q.push_back(p);
  endtask

  task automatic test_reset();
    @(negedge clk);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 3'd0, 32'd40, 32'd2, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    push_alu(4'd0, 32'd40, 32'd2, 5'd9);
    @(negedge clk);
    exp_pkt = exp_q.pop_front();
    checks++;
    if (ex_mem !== exp_pkt) begin
      failures++;
      $display("[TB] FAIL pre_reset_add got=%h exp=%h", ex_mem, exp_pkt);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ex_mem !== '0 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset ex_mem=%h stall=%b exp=0/0", ex_mem, stall);
    end
    @(negedge clk);
    checks++;
    if (ex_mem !== '0) begin
      failures++;
      $display("[TB] FAIL reset_hold got=%h exp=0", ex_mem);
    end
    idleInputs();
    reset = 1'b1;
  endtask

  task automatic test_alu();
    alu_vec_t vecs[$];
    alu_vec_t t;
    ex_mem_t  p;
    vecs.push_back('{1'b1, 4'd0,  1'b0, 32'h7FFF_FFFF, 32'd1,         32'd0,  5'd5,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd7,  1'b1, 32'h8000_0000, 32'd0,         32'd4,  5'd6,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd9,  1'b0, 32'd1,         32'hFFFF_FFFF, 32'd0,  5'd7,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd1,  1'b0, 32'd0,         32'd1,         32'd0,  5'd8,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd8,  1'b0, 32'h8000_0000, 32'd1,         32'd0,  5'd9,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd5,  1'b1, 32'd1,         32'hAA,        32'h23, 5'd10, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd6,  1'b1, 32'hF000_0000, 32'd0,         32'd4,  5'd11, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'd10, 1'b1, 32'd5,         32'd6,         32'h1234, 5'd12, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd13, 1'b0, 32'd5,         32'd6,         32'd0,  5'd13, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b0, 32'd5,         32'd6,         32'd0,  5'd14, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) begin
      t.v = 1'b1; t.op = 4'($urandom_range(0, 15)); t.src = 1'($urandom);
      t.a = $urandom; t.b = $urandom; t.im = $urandom; t.d = 5'($urandom);
      t.rw = 1'($urandom); t.m2r = 1'($urandom); t.mw = 1'($urandom);
      vecs.push_back(t);
    end
    for (int i = 0; i <= vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_pkt = exp_q.pop_front();
        checks++;
        if (ex_mem !== exp_pkt) begin
          failures++;
          $display("[TB] FAIL alu[%0d] got=%h exp=%h", i - 1, ex_mem, exp_pkt);
        end
      end
      if (i < vecs.size()) begin
        t = vecs[i];
        applyStimulus(t.v, t.op, t.src, 1'b0, 3'd0, t.a, t.b, t.im, t.d, t.rw, t.m2r, t.mw);
        p = '0;
        if (t.v) begin
          p.alu_result = alu_model(t.op, t.a, t.src ? t.im : t.b);
          p.rs2_data = t.b; p.rd = t.d;
          p.RegWrite = t.rw; p.MemToReg = t.m2r; p.MemWrite = t.mw;
        end
        exp_q.push_back(p);
      end
    end
    idleInputs();
  endtask

  task automatic test_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] d);
    ex_mem_t p;
    int      stall_cnt;
    int      bad_bubbles;
    stall_cnt = 0;
    bad_bubbles = 0;
    @(negedge clk);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b1, op, a, b, 32'd0, d, 1'b1, 1'b0, 1'b0);
    p.alu_result = md_model(op, a, b);
    p.rs2_data = b; p.rd = d; p.RegWrite = 1'b1; p.MemToReg = 1'b0; p.MemWrite = 1'b0;
    exp_q.push_back(p);
    #1;
    for (int k = 1; k <= 34; k++) begin
      if (stall === 1'b1) stall_cnt++;
      @(posedge clk);
      @(negedge clk);
      if (k < 34) begin
        if (ex_mem !== '0) bad_bubbles++;
      end else begin
        exp_pkt = exp_q.pop_front();
        checks++;
        if (ex_mem !== exp_pkt) begin
          failures++;
          $display("[TB] FAIL md op=%0d a=%h b=%h got=%h exp=%h", op, a, b,
                   ex_mem.alu_result, exp_pkt.alu_result);
        end
      end
    end
    idleInputs();
    checks++;
    if (stall_cnt !== 33) begin
      failures++;
      $display("[TB] FAIL md_stall_cycles op=%0d got=%0d exp=33", op, stall_cnt);
    end
    checks++;
    if (bad_bubbles !== 0) begin
      failures++;
      $display("[TB] FAIL md_bubbles op=%0d non_bubble_cycles=%0d exp=0", op, bad_bubbles);
    end
  endtask

  task automatic test_back_to_back_add(input string tag);
    int bad;
    @(negedge clk);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 3'd0, 32'd100, 32'd23, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    push_alu(4'd0, 32'd100, 32'd23, 5'd4);
    @(negedge clk);
    idleInputs();
    exp_pkt = exp_q.pop_front();
    checks++;
    if (ex_mem !== exp_pkt) begin
      failures++;
      $display("[TB] FAIL add_after_%s got=%h exp=%h", tag, ex_mem, exp_pkt);
    end
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ex_mem !== '0 || stall !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL quiet_after_%s busy_cycles=%0d exp=0", tag, bad);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b1, 3'd5, 32'd100, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_stall got=%b exp=1", stall);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_stall got=%b exp=0", stall);
    end
    @(negedge clk);
    idleInputs();
    #1;
    checks++;
    if (ex_mem !== '0 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_flush ex_mem=%h stall=%b exp=0/0", ex_mem, stall);
    end
    test_back_to_back_add("flush");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b1, 3'd5, 32'd100, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ex_mem !== '0 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_abort ex_mem=%h stall=%b exp=0/0", ex_mem, stall);
    end
    @(negedge clk);
    idleInputs();
    reset = 1'b1;
    test_back_to_back_add("reset");
  endtask

  initial begin
    $display("[TB] execute_stage bench start");
    reset = 1'b1;
    idleInputs();
    #1 reset = 1'b0;
    #12;
    @(negedge clk);
    reset = 1'b1;

    test_reset();
    test_alu();
    test_muldiv(3'd1, 32'hFFFF_FFFF, 32'd2,         5'd15);
    test_muldiv(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    test_muldiv(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
    test_muldiv(3'd5, 32'd7,         32'd0,         5'd18);
    test_muldiv(3'd7, 32'd7,         32'd0,         5'd19);
    test_muldiv(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd20);
    test_muldiv(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd21);
    test_muldiv(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd22);
    test_muldiv(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23);
    test_muldiv(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd24);
    test_muldiv(3'd4, 32'd0,         32'd0,         5'd25);
    for (int i = 0; i < 6; i++)
      test_muldiv(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(1, 31)));
    test_flush();
    test_reset_abort();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
